// File: rtl/shot_launch_controller.sv
// Player-input front end: aim buttons and hold-to-charge fire become an angle and power,
// which are turned into (v0x, v0y) and handed to the integrator over valid/ready.
module shot_launch_controller #(
  parameter int ANGLE_INIT = 45,
  parameter int ANGLE_MIN  = 15,
  parameter int ANGLE_MAX  = 75,
  parameter int ANGLE_STEP = 5,
  parameter int POWER_MAX  = 255,
  parameter int CHARGE_DIV = 250000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_fire,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              launch_ready,
  input  logic              shot_done,
  output logic [6:0]        angle,
  output logic [7:0]        power,
  output logic              launch_valid,
  output logic signed [9:0] v0x,
  output logic signed [9:0] v0y,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  localparam int CW = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHARGE = 3'd1,
    S_CALC   = 3'd2,
    S_LAUNCH = 3'd3,
    S_FLIGHT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      angle_q, angle_d;
  logic [7:0]      power_q, power_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      v0x_q, v0x_d, v0y_q, v0y_d;
  // Bit 0/1 form the synchroniser, bit 2 holds the previous synchronised level for edge detect.
  logic [2:0]      fire_q, up_q, down_q;

  logic            fire, fire_rise, up_rise, down_rise;
  logic [4:0]      lut_idx;
  logic [15:0]     prod_x, prod_y;

  // Unsigned Q1.7 cosine, 5-degree steps from 0 to 90; sine is read as cos(90 - a).
  function automatic logic [7:0] cos_lut(input logic [4:0] idx);
    case (idx)
      5'd0:  cos_lut = 8'd128;  5'd1:  cos_lut = 8'd128;  5'd2:  cos_lut = 8'd126;
      5'd3:  cos_lut = 8'd124;  5'd4:  cos_lut = 8'd120;  5'd5:  cos_lut = 8'd116;
      5'd6:  cos_lut = 8'd111;  5'd7:  cos_lut = 8'd105;  5'd8:  cos_lut = 8'd98;
      5'd9:  cos_lut = 8'd91;   5'd10: cos_lut = 8'd82;   5'd11: cos_lut = 8'd73;
      5'd12: cos_lut = 8'd64;   5'd13: cos_lut = 8'd54;   5'd14: cos_lut = 8'd44;
      5'd15: cos_lut = 8'd33;   5'd16: cos_lut = 8'd22;   5'd17: cos_lut = 8'd11;
      default: cos_lut = 8'd0;
    endcase
  endfunction

  assign fire      = fire_q[1];
  assign fire_rise = fire_q[1] & ~fire_q[2];
  assign up_rise   = up_q[1] & ~up_q[2];
  assign down_rise = down_q[1] & ~down_q[2];

  assign lut_idx = 5'(angle_q / 7'd5);
  assign prod_x  = 16'(power_q) * 16'(cos_lut(lut_idx));
  assign prod_y  = 16'(power_q) * 16'(cos_lut(5'd18 - lut_idx));

  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    power_d = power_q;
    cnt_d   = cnt_q;
    v0x_d   = v0x_q;
    v0y_d   = v0y_q;
    case (state_q)
      S_IDLE: begin
        if (up_rise && !down_rise)
          angle_d = (angle_q >= 7'(ANGLE_MAX - ANGLE_STEP)) ? 7'(ANGLE_MAX) : angle_q + 7'(ANGLE_STEP);
        else if (down_rise && !up_rise)
          angle_d = (angle_q <= 7'(ANGLE_MIN + ANGLE_STEP)) ? 7'(ANGLE_MIN) : angle_q - 7'(ANGLE_STEP);
        if (fire_rise) begin
          state_d = S_CHARGE;
          power_d = '0;
          cnt_d   = '0;
        end
      end
      S_CHARGE: begin
        if (!fire) begin
          state_d = (power_q == 8'd0) ? S_IDLE : S_CALC;
        end else if (cnt_q == CW'(CHARGE_DIV - 1)) begin
          cnt_d = '0;
          if (power_q < 8'(POWER_MAX)) power_d = power_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CALC: begin
        v0x_d   = 10'(prod_x >> 7);
        v0y_d   = 10'(prod_y >> 7);
        state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (launch_ready) state_d = S_FLIGHT;
      end
      S_FLIGHT: begin
        if (shot_done) begin
          state_d = S_IDLE;
          power_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      angle_q <= 7'(ANGLE_INIT);
      power_q <= '0;
      cnt_q   <= '0;
      v0x_q   <= '0;
      v0y_q   <= '0;
      fire_q  <= '0;
      up_q    <= '0;
      down_q  <= '0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      power_q <= power_d;
      cnt_q   <= cnt_d;
      v0x_q   <= v0x_d;
      v0y_q   <= v0y_d;
      fire_q  <= {fire_q[1:0], btn_fire};
      up_q    <= {up_q[1:0], btn_up};
      down_q  <= {down_q[1:0], btn_down};
    end
  end

  // Handshake: (v0x, v0y) transfer on the rising edge where launch_valid and launch_ready are both high.
  assign launch_valid = (state_q == S_LAUNCH);
  assign busy         = (state_q != S_IDLE);
  assign state_dbg    = state_q;
  assign angle        = angle_q;
  assign power        = power_q;
  assign v0x          = v0x_q;
  assign v0y          = v0y_q;

endmodule

// File: tb/tb_shot_launch_controller.sv
// Bench for shot_launch_controller: directed scenarios plus random button traffic,
// every cycle compared against a behavioural model built from the launch rules.
module tb_shot_launch_controller;

  localparam int DIV = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              btn_fire = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic              launch_ready = 1'b0, shot_done = 1'b0;
  logic [6:0]        angle;
  logic [7:0]        power;
  logic              launch_valid;
  logic signed [9:0] v0x, v0y;
  logic              busy;
  logic [2:0]        state_dbg;

  shot_launch_controller #(.CHARGE_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .btn_fire(btn_fire), .btn_up(btn_up), .btn_down(btn_down),
    .launch_ready(launch_ready), .shot_done(shot_done), .angle(angle), .power(power),
    .launch_valid(launch_valid), .v0x(v0x), .v0y(v0y), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  int cos_tab[19], sin_tab[19];
  int m_ph, m_ang, m_pw, m_cnt, m_vx, m_vy;
  int hf[3], hu[3], hd[3];   // [0]=first sync stage, [1]=usable level, [2]=previous usable level

  initial begin
    for (int i = 0; i < 19; i++) begin
      cos_tab[i] = $rtoi(128.0 * $cos(i * 5.0 * 3.14159265358979 / 180.0) + 0.5);
      sin_tab[i] = $rtoi(128.0 * $sin(i * 5.0 * 3.14159265358979 / 180.0) + 0.5);
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m_ph = 0; m_ang = 45; m_pw = 0; m_cnt = 0; m_vx = 0; m_vy = 0;
      for (int i = 0; i < 3; i++) begin hf[i] = 0; hu[i] = 0; hd[i] = 0; end
    end else begin
      automatic bit fire_lvl = (hf[1] != 0);
      automatic bit fire_e = (hf[1] != 0) && (hf[2] == 0);
      automatic bit up_e   = (hu[1] != 0) && (hu[2] == 0);
      automatic bit dn_e   = (hd[1] != 0) && (hd[2] == 0);
      case (m_ph)
        0: begin
          if (up_e && !dn_e) m_ang = (m_ang + 5 > 75) ? 75 : m_ang + 5;
          if (dn_e && !up_e) m_ang = (m_ang - 5 < 15) ? 15 : m_ang - 5;
          if (fire_e) begin m_ph = 1; m_pw = 0; m_cnt = 0; end
        end
        1: begin
          if (!fire_lvl) m_ph = (m_pw == 0) ? 0 : 2;
          else begin
            m_cnt = (m_cnt + 1) % DIV;
            if (m_cnt == 0 && m_pw < 255) m_pw++;
          end
        end
        2: begin
          m_vx = (m_pw * cos_tab[m_ang / 5]) / 128;
          m_vy = (m_pw * sin_tab[m_ang / 5]) / 128;
          m_ph = 3;
        end
        3: if (launch_ready) m_ph = 4;
        default: if (shot_done) begin m_ph = 0; m_pw = 0; end
      endcase
      hf[2] = hf[1]; hf[1] = hf[0]; hf[0] = int'(btn_fire);
      hu[2] = hu[1]; hu[1] = hu[0]; hu[0] = int'(btn_up);
      hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = int'(btn_down);
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_err = 0;
  bit chk_en = 1'b0, auto_mode = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (reset) begin
      check("rst_state", int'(state_dbg), 0);
      check("rst_angle", int'(angle), 45);
      check("rst_power", int'(power), 0);
      check("rst_valid", int'(launch_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_v0x", int'(v0x), 0);
      check("rst_v0y", int'(v0y), 0);
    end else begin
      check("state", int'(state_dbg), m_ph);
      check("angle", int'(angle), m_ang);
      check("power", int'(power), m_pw);
      check("valid", int'(launch_valid), (m_ph == 3) ? 1 : 0);
      check("busy", int'(busy), (m_ph != 0) ? 1 : 0);
      check("v0x", int'(v0x), m_vx);
      check("v0y", int'(v0y), m_vy);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_all();
    if (auto_mode) begin
      launch_ready = ($urandom_range(0, 3) != 0);
      shot_done    = ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic press(input int which, input int hold);
    if (which == 0) btn_up = 1'b1; else btn_down = 1'b1;
    repeat (hold) tick();
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (2) tick();
  endtask

  task automatic hold_fire(input int cycles);
    btn_fire = 1'b1;
    repeat (cycles) tick();
    btn_fire = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int n);
    n = 0;
    while (!launch_valid && n < 20) begin tick(); n++; end
    check(nm, int'(launch_valid), 1);
  endtask

  task automatic wait_state(input string nm, input int code, input int budget);
    int n = 0;
    while (int'(state_dbg) != code && n < budget) begin tick(); n++; end
    check(nm, int'(state_dbg), code);
  endtask

  task automatic handshake_and_land();
    launch_ready = 1'b1; tick(); launch_ready = 1'b0;
    check("hs_state", int'(state_dbg), 4);
    check("hs_valid", int'(launch_valid), 0);
    repeat (3) tick();
    shot_done = 1'b1; tick(); shot_done = 1'b0; tick();
    check("land_state", int'(state_dbg), 0);
    check("land_power", int'(power), 0);
  endtask

  task automatic do_reset_pulse();
    @(posedge clk); #2; reset = 1'b1; #1;
    check("arst_valid", int'(launch_valid), 0);
    check("arst_state", int'(state_dbg), 0);
    check("arst_angle", int'(angle), 45);
    repeat (2) tick();
    @(posedge clk); #2; reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2; reset = 1'b0;
    chk_en = 1'b1;
    tick();

    // same-cycle up and down leave the angle alone
    btn_up = 1'b1; btn_down = 1'b1; repeat (2) tick();
    btn_up = 1'b0; btn_down = 1'b0; repeat (3) tick();
    check("both_edges_angle", int'(angle), 45);

    // angle stepping and saturation
    repeat (3) press(0, 2);
    tick();
    check("angle_up3", int'(angle), 60);
    repeat (10) press(0, 2);
    tick();
    check("angle_max", int'(angle), 75);
    repeat (13) press(1, 2);
    tick();
    check("angle_min", int'(angle), 15);
    repeat (6) press(0, 2);
    tick();
    check("angle_back45", int'(angle), 45);

    // charge to 200 at 45 degrees; valid rises on the 4th negedge after raw release
    hold_fire(801);
    n = 0;
    while (!launch_valid && n < 20) begin tick(); n++; end
    check("t3_latency", n, 4);
    check("t3_power", int'(power), 200);
    check("t3_v0x", int'(v0x), 142);
    check("t3_v0y", int'(v0y), 142);
    handshake_and_land();
    check("t3_v0x_kept", int'(v0x), 142);

    // 60 degrees, power 128, ready held low 20 cycles
    repeat (3) press(0, 2);
    tick();
    hold_fire(513);
    wait_valid("t4_valid_rise", n);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t4_valid_hold", int'(launch_valid), 1);
      check("t4_v0x", int'(v0x), 64);
      check("t4_v0y", int'(v0y), 111);
    end
    handshake_and_land();

    // short fire pulse: no launch
    hold_fire(3);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t5_no_valid", int'(launch_valid), 0);
    end
    check("t5_state", int'(state_dbg), 0);
    check("t5_power", int'(power), 0);

    // power saturation
    hold_fire(1100);
    wait_valid("t5_sat_valid", n);
    check("t5_sat_power", int'(power), 255);
    handshake_and_land();

    // reset in LAUNCH, then in FLIGHT; shot_done in IDLE ignored
    hold_fire(20);
    wait_state("t6_in_launch", 3, 20);
    do_reset_pulse();
    tick();
    hold_fire(20);
    wait_valid("t6_valid2", n);
    launch_ready = 1'b1; tick(); launch_ready = 1'b0;
    wait_state("t6_in_flight", 4, 5);
    do_reset_pulse();
    tick();
    shot_done = 1'b1; tick(); shot_done = 1'b0; tick();
    check("t6_done_idle_state", int'(state_dbg), 0);
    check("t6_done_idle_angle", int'(angle), 45);

    // random traffic
    auto_mode = 1'b1;
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 4))
        0: press(0, $urandom_range(1, 4));
        1: press(1, $urandom_range(1, 4));
        2: hold_fire($urandom_range(1, 60));
        3: begin
          btn_up = ($urandom_range(0, 1) != 0); btn_down = ($urandom_range(0, 1) != 0);
          btn_fire = ($urandom_range(0, 1) != 0);
          repeat ($urandom_range(1, 6)) tick();
          btn_up = 1'b0; btn_down = 1'b0; btn_fire = 1'b0;
        end
        default: repeat ($urandom_range(1, 10)) tick();
      endcase
    end
    auto_mode = 1'b0;
    launch_ready = 1'b1;
    shot_done = 1'b0;
    n = 0;
    while (int'(state_dbg) != 0 && n < 200) begin
      shot_done = (int'(state_dbg) == 4); tick(); n++;
    end
    shot_done = 1'b0;
    tick();
    check("drain_idle", int'(state_dbg), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
